// File: rtl/param_memory_model.sv
// Parameterised single-port memory model with fixed, independently configurable
// read and write response latencies. One request in flight at a time.
// Optional build macro PARAM_MEMORY_MODEL_BYTE_WRITE_EN enables per-byte write
// masking via inputByteEn; without it writes always update the full word.
module param_memory_model #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned READ_LATENCY  = 1,
   parameter int unsigned WRITE_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WIDTH-1:0]   inputAddress,
   input  logic [DATA_WIDTH-1:0]   inputWdata,
   input  logic                    inputWnR,
   input  logic                    inputSelect,
   input  logic [DATA_WIDTH/8-1:0] inputByteEn,
   output logic [DATA_WIDTH-1:0]   outputRdata,
   output logic                    outputValid,
   output logic                    outputBusy
);

   localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
   localparam logic [3:0]  ReadCnt  = 4'(READ_LATENCY - 1);
   localparam logic [3:0]  WriteCnt = 4'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                  state;
   logic [3:0]              counter;
   logic [ADDR_WIDTH-1:0]   capAddr;
   logic [DATA_WIDTH-1:0]   capWdata;
   logic                    capWnR;

   // Storage is deliberately outside the reset domain: reset never clears it.
   logic [DATA_WIDTH-1:0]   mem [Depth] = '{default: '0};

   logic                    acceptNow;
   logic [3:0]              acceptCnt;
   logic                    enterResp;
   logic                    accWnR;
   logic [ADDR_WIDTH-1:0]   accAddr;
   logic [DATA_WIDTH-1:0]   accWdata;
   logic [DATA_WIDTH-1:0]   writeWord;

   // Access parameters for the edge entering RESP; a latency-1 request uses the
   // live inputs because nothing has been captured yet.
   assign acceptNow = rstn && (state == StIdle) && inputSelect;
   assign acceptCnt = inputWnR ? WriteCnt : ReadCnt;
   assign enterResp = (acceptNow && (acceptCnt == 4'd0)) ||
                      (rstn && (state == StWait) && (counter == 4'd1));
   assign accWnR    = acceptNow ? inputWnR : capWnR;
   assign accAddr   = acceptNow ? inputAddress : capAddr;
   assign accWdata  = acceptNow ? inputWdata : capWdata;

`ifdef PARAM_MEMORY_MODEL_BYTE_WRITE_EN
   logic [DATA_WIDTH/8-1:0] capByteEn;
   logic [DATA_WIDTH/8-1:0] accByteEn;

   assign accByteEn = acceptNow ? inputByteEn : capByteEn;

   // Merge enabled byte lanes of the new data into the stored word.
   always_comb begin
      writeWord = mem[accAddr];
      for (int i = 0; i < int'(DATA_WIDTH / 8); i++) begin
         if (accByteEn[i]) writeWord[8*i +: 8] = accWdata[8*i +: 8];
      end
   end

   // Byte enables are held alongside the rest of the captured request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) capByteEn <= '0;
      else if (acceptNow) capByteEn <= inputByteEn;
   end
`else
   logic unusedByteEn;
   assign unusedByteEn = ^inputByteEn;

   // Full-word writes: byte enables have no effect in this build.
   always_comb begin
      writeWord = accWdata;
   end
`endif

   // Write commit on the edge entering RESP; gated by rstn so a reset edge never commits.
   always_ff @(posedge clk) begin
      if (enterResp && accWnR) mem[accAddr] <= writeWord;
   end

   // Request FSM with registered valid/busy/rdata.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= StIdle;
         counter     <= 4'd0;
         capAddr     <= '0;
         capWdata    <= '0;
         capWnR      <= 1'b0;
         outputValid <= 1'b0;
         outputBusy  <= 1'b0;
         outputRdata <= '0;
      end else begin
         outputValid <= 1'b0;
         outputRdata <= '0;
         case (state)
            StIdle: begin
               outputBusy <= 1'b0;
               if (inputSelect) begin
                  capAddr    <= inputAddress;
                  capWdata   <= inputWdata;
                  capWnR     <= inputWnR;
                  counter    <= acceptCnt;
                  outputBusy <= 1'b1;
                  if (acceptCnt == 4'd0) begin
                     state       <= StResp;
                     outputValid <= 1'b1;
                     if (!inputWnR) outputRdata <= mem[inputAddress];
                  end else begin
                     state <= StWait;
                  end
               end
            end
            StWait: begin
               counter <= counter - 4'd1;
               if (counter == 4'd1) begin
                  state       <= StResp;
                  outputValid <= 1'b1;
                  if (!capWnR) outputRdata <= mem[capAddr];
               end
            end
            StResp: begin
               state      <= StIdle;
               outputBusy <= 1'b0;
            end
            default: begin
               state      <= StIdle;
               outputBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/param_memory_model.md
PARAM_MEMORY_MODEL -- requirements
Module: param_memory_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width in bits; multiple of 8, 8..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: word address width; depth 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1: cycles from read acceptance to response; legal range 1..15.
REQ-004 SHALL have parameter WRITE_LATENCY, default 1: cycles from write acceptance to response; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port inputAddress  input  ADDR_WIDTH  word address of request.
REQ-008 SHALL have port inputWdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port inputWnR  input  1  1 = write, 0 = read.
REQ-010 SHALL have port inputSelect  input  1  request strobe.
REQ-011 SHALL have port inputByteEn  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits 8i+7:8i.
REQ-012 SHALL have port outputRdata  output  DATA_WIDTH  read response data.
REQ-013 SHALL have port outputValid  output  1  one-cycle response strobe, reads and writes.
REQ-014 SHALL have port outputBusy  output  1  high whenever a request is in flight; request not accepted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; outputBusy = (state != IDLE).
REQ-016 SHALL accept a request on a rising edge where state is IDLE and inputSelect is 1, capturing address, wdata, byte enables and WnR.
REQ-017 SHALL on acceptance load an internal counter with (latency-1), latency = WRITE_LATENCY or READ_LATENCY per captured WnR; go to RESP if counter value 0, else WAIT.
REQ-018 SHALL in WAIT decrement the counter each cycle and go to RESP on the edge where it reaches 0.
REQ-019 SHALL perform the memory access on the edge entering RESP: write commits to array; read samples array into outputRdata.
REQ-020 SHALL assert outputValid for exactly the one cycle in RESP, i.e. L cycles after the accepting edge; RESP always returns to IDLE on the next edge.
REQ-021 SHALL drive outputRdata to 0 whenever outputValid is 0 and during a write response.
REQ-022 SHALL ignore inputSelect while outputBusy is 1; a held inputSelect is re-accepted on the first IDLE edge (max throughput one request per L+1 cycles).
REQ-023 SHALL return newly written data for a read issued after a write response to the same address (no stale data).
REQ-024 SHALL wrap no addresses: all 2**ADDR_WIDTH locations distinct and accessible, including all-ones.
REQ-025 SHALL initialise every memory word to 0 at simulation time 0.

Reset
REQ-026 SHALL on rstn low immediately force state IDLE, counter 0, outputValid 0, outputRdata 0, outputBusy 0.
REQ-027 SHALL abort an in-flight request on reset in WAIT without committing its write; memory contents are never cleared by reset.
REQ-028 SHALL accept no request on the first edge on which rstn is low; acceptance resumes on the first edge with rstn high.

Configuration
REQ-029 SHALL use macro PARAM_MEMORY_MODEL_BYTE_WRITE_EN: when defined, a write updates only byte lanes whose inputByteEn bit is 1; others retain prior value.
REQ-030 SHALL, when PARAM_MEMORY_MODEL_BYTE_WRITE_EN is undefined, keep port inputByteEn but ignore it; every write updates the full word.

Verification
REQ-031 SHALL cover: defaults, write 0xBEEF @0x0010, then read 0x0010 -> write valid 1 cycle after accept, read valid 1 cycle after accept with outputRdata 0xBEEF.
REQ-032 SHALL cover: READ_LATENCY=4, WRITE_LATENCY=2, inputSelect held high for reads @0xFFFF -> outputBusy high 4 cycles, valid every 5th cycle, data read back correct.
REQ-033 SHALL cover: macro defined, word 0x1234 @0x0020 then write 0xABCD with inputByteEn=2'b10 -> read returns 0xAB34; macro undefined -> returns 0xABCD.
REQ-034 SHALL cover: READ_LATENCY=8, rstn pulsed low in WAIT -> outputValid never asserts, outputBusy 0 immediately, memory unchanged.
REQ-035 SHALL cover: WRITE_LATENCY=3, write 0x5555 @0x0001 aborted by reset in WAIT -> subsequent read @0x0001 returns 0x0000.
REQ-036 SHALL cover: DATA_WIDTH=32, ADDR_WIDTH=8, write 0xDEADBEEF @0xFF, read @0xFF and @0x00 -> 0xDEADBEEF and 0x00000000.
